// File: rtl/m_axi_cmd.sv
// -----------------------------------------------------------------------------
// m_axi_cmd
//   Single-outstanding command bridge onto an AXI master port. It takes one
//   read or write command at a time from a simple valid/ready command port and
//   runs a single-beat AXI transaction. When the transaction completes, it
//   returns a one-cycle response pulse.
//
// Optional feature:
//   M_AXI_TIMEOUT_EN -- when defined, the B/R wait is bounded to TIMEOUT_CYCLES
//   cycles. On expiry the block responds with resp 2'b11 and rdata 0.
//
// Parameters:
//   AXI_ID          constant ID driven on awid_o / arid_o
//   TIMEOUT_CYCLES  response-wait limit in cycles (1..65535), timeout build only
//
// Ports:
//   clk, areset                       clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o         command handshake, ready only when idle
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_wstrb_i          command payload (1 = write, 0 = read)
//   rsp_valid_o, rsp_rdata_o,
//   rsp_resp_o                        completion pulse, read data, BRESP/RRESP
//   aw*, w*, b*                       AXI write address / data / response
//   ar*, r*                           AXI read address / data
// -----------------------------------------------------------------------------
module m_axi_cmd #(
  parameter logic [3:0]  AXI_ID         = 4'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        areset,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  // response port
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  // AXI write address
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  // AXI write data
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  // AXI write response
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  // AXI read address
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  // AXI read data
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_resp_q;

  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic        r_hs;
  logic        to_fire;

`ifdef M_AXI_TIMEOUT_EN
  // Wait counter: zero on the first cycle of WRESP/RDATA, +1 per cycle there.
  logic [15:0] wait_cnt_q;
  logic        timeout_hit;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wait_cnt_q <= '0;
    end else if (state_q == WRESP || state_q == RDATA) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // The last permitted wait cycle is count TIMEOUT_CYCLES-1. The response then
  // lands TIMEOUT_CYCLES cycles after entering the wait state.
  assign timeout_hit = (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // State register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and channel controls
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    arvalid_o   = 1'b0;
    bready_o    = 1'b0;
    rready_o    = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    b_hs        = 1'b0;
    r_hs        = 1'b0;
    to_fire     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          state_d = cmd_write_i ? WADDR : RADDR;
        end
      end

      WADDR: begin
        // AW and W complete independently. Leave once both are done,
        // counting a handshake that happens in this same cycle.
        awvalid_o = !aw_done_q;
        wvalid_o  = !w_done_q;
        aw_hs     = awvalid_o && awready_i;
        w_hs      = wvalid_o && wready_i;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WRESP;
        end
      end

      WRESP: begin
        bready_o = 1'b1;
        b_hs     = bvalid_i;
`ifdef M_AXI_TIMEOUT_EN
        to_fire  = !bvalid_i && timeout_hit;
`endif
        if (b_hs || to_fire) begin
          state_d = IDLE;
        end
      end

      RADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) begin
          state_d = RDATA;
        end
      end

      RDATA: begin
        rready_o = 1'b1;
        r_hs     = rvalid_i;
`ifdef M_AXI_TIMEOUT_EN
        to_fire  = !rvalid_i && timeout_hit;
`endif
        if (r_hs || to_fire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command capture, per-channel done flags, response registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      if (cmd_valid_i && cmd_ready_o) begin
        addr_q    <= cmd_addr_i;
        wdata_q   <= cmd_wdata_i;
        wstrb_q   <= cmd_wstrb_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end

      if (aw_hs) begin
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
      end

      if (b_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= bresp_i;
      end else if (r_hs) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rdata_i;
        rsp_resp_q  <= rresp_i;
      end else if (to_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= 2'b11;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;

  assign awid_o   = AXI_ID;
  assign arid_o   = AXI_ID;
  assign awaddr_o = addr_q;
  assign araddr_o = addr_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;
  assign wlast_o  = 1'b1;

endmodule
